// File: rtl/ram_burst_reader.sv
// Read-side burst sequencer for the dual-port RAM: issues read strobes/addresses,
// absorbs the one-cycle read latency in a 3-entry FIFO and streams words with tlast.
module ram_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic                  rd_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                  tvalid_o,
    input  logic                  tready_i,
    output logic [DATA_WIDTH-1:0] tdata_o,
    output logic                  tlast_o,
    output logic                  busy_o
);

    localparam int FIFO_DEPTH = 3;

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic                  pending_q, pending_d;
    logic                  pending_last_q, pending_last_d;
    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];
    logic                  fifo_last_q [FIFO_DEPTH];
    logic                  fifo_last_d [FIFO_DEPTH];
    logic [1:0]            count_q, count_d;

    logic                  rd;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [1:0]            push_idx;

    // Reads in flight plus words held may never exceed the FIFO, so it cannot overflow.
    assign rd = (state_q == READ) && (remaining_q != '0) &&
                (({1'b0, count_q} + {2'b00, pending_q}) < 3'(FIFO_DEPTH));

    assign fifo_push = pending_q;
    assign fifo_pop  = tvalid_o && tready_i;
    assign push_idx  = count_q - 2'(fifo_pop);

    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q == READ);
    assign rd_o        = rd;
    assign rd_addr_o   = addr_q;
    assign tvalid_o    = (count_q != 2'd0);
    assign tdata_o     = fifo_data_q[0];
    assign tlast_o     = tvalid_o && fifo_last_q[0];

    always_comb begin
        // NOTE: every _d signal takes its held value first, so no path can infer a latch.
        state_d        = state_q;
        addr_d         = addr_q;
        remaining_d    = remaining_q;
        pending_d      = rd;
        pending_last_d = pending_last_q;
        fifo_data_d    = fifo_data_q;
        fifo_last_d    = fifo_last_q;
        count_d        = count_q - 2'(fifo_pop) + 2'(fifo_push);

        case (state_q)
            IDLE: begin
                if (cmd_valid_i && (cmd_len_i != '0)) begin
                    state_d     = READ;
                    addr_d      = cmd_addr_i;
                    remaining_d = cmd_len_i;
                end
            end
            READ: begin
                if (rd) begin
                    addr_d         = addr_q + ADDR_WIDTH'(1);
                    remaining_d    = remaining_q - LEN_WIDTH'(1);
                    pending_last_d = (remaining_q == LEN_WIDTH'(1));
                end
                if (fifo_pop && fifo_last_q[0]) begin
                    state_d = IDLE;
                end
            end
        endcase

        // Shift-register FIFO: entry 0 is always the head, vacated slots refill with zero.
        if (fifo_pop) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                fifo_data_d[i] = fifo_data_q[i+1];
                fifo_last_d[i] = fifo_last_q[i+1];
            end
            fifo_data_d[FIFO_DEPTH-1] = '0;
            fifo_last_d[FIFO_DEPTH-1] = 1'b0;
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_push && (push_idx == 2'(i))) begin
                fifo_data_d[i] = rd_data_i;
                fifo_last_d[i] = pending_last_q;
            end
        end
    end

    // NOTE: the FIFO storage is reset too, so tdata_o is a defined 0 straight out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            remaining_q    <= '0;
            pending_q      <= 1'b0;
            pending_last_q <= 1'b0;
            count_q        <= 2'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q        <= state_d;
            addr_q         <= addr_d;
            remaining_q    <= remaining_d;
            pending_q      <= pending_d;
            pending_last_q <= pending_last_d;
            count_q        <= count_d;
            fifo_data_q    <= fifo_data_d;
            fifo_last_q    <= fifo_last_d;
        end
    end

    fifo_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
        !(fifo_push && !fifo_pop && (count_q == 2'(FIFO_DEPTH))));

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: RAM model, queue-based expected stream, literal
// timing checks for the basic, wrap, backpressure, len=0 and reset scenarios.
module tb_ram_burst_reader;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int LW    = 6;
    localparam int DEPTH = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [AW-1:0] cmd_addr_i = '0;
    logic [LW-1:0] cmd_len_i = '0;
    logic [AW-1:0] rd_addr_o;
    logic          rd_o;
    logic [DW-1:0] rd_data_i = '0;
    logic          tvalid_o;
    logic          tready_i = 1'b1;
    logic [DW-1:0] tdata_o;
    logic          tlast_o;
    logic          busy_o;

    logic [DW-1:0] ram [DEPTH];
    word_t         exp_q[$];
    logic [AW-1:0] exp_addr_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int issued   = 0;
    int popped   = 0;
    int hs_count = 0;
    int last_count = 0;
    int tready_mode = 1;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] last_hs_data = '0;
    logic          last_hs_last = 1'b0;

    ram_burst_reader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_addr_i (cmd_addr_i),
        .cmd_len_i  (cmd_len_i),
        .rd_addr_o  (rd_addr_o),
        .rd_o       (rd_o),
        .rd_data_i  (rd_data_i),
        .tvalid_o   (tvalid_o),
        .tready_i   (tready_i),
        .tdata_o    (tdata_o),
        .tlast_o    (tlast_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // RAM read port with one cycle of registered latency
    always @(posedge clk_i) if (rd_o) rd_data_i <= ram[rd_addr_o];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_i);
            #2;
            case (tready_mode)
                0:       tready_i = 1'b0;
                1:       tready_i = 1'b1;
                default: tready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Compare process: addresses, in-flight bound, hold-while-stalled, stream contents
    always @(negedge clk_i) begin
        if (rst_i) begin
            prev_stall = 1'b0;
            issued = 0;
            popped = 0;
        end else begin
            if (rd_o) begin
                if (exp_addr_q.size() == 0) begin
                    check("rd_unexpected", 32'(rd_o), 32'd0);
                end else begin
                    check("rd_addr", 32'(rd_addr_o), 32'(exp_addr_q.pop_front()));
                end
                check("inflight_below_3", 32'((issued - popped) < 3), 32'd1);
                issued++;
            end
            if (prev_stall) begin
                check("hold_tvalid", 32'(tvalid_o), 32'd1);
                check("hold_tdata", 32'(tdata_o), 32'(prev_data));
            end
            if (tvalid_o && tready_i) begin
                if (exp_q.size() == 0) begin
                    check("word_unexpected", 32'(tvalid_o), 32'd0);
                end else begin
                    word_t e;
                    e = exp_q.pop_front();
                    check("tdata", 32'(tdata_o), 32'(e.data));
                    check("tlast", 32'(tlast_o), 32'(e.last));
                end
                popped++;
                hs_count++;
                if (tlast_o) last_count++;
                last_hs_data = tdata_o;
                last_hs_last = tlast_o;
            end
            prev_stall = tvalid_o && !tready_i;
            prev_data  = tdata_o;
        end
    end

    task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l);
        check("cmd_ready_before_cmd", 32'(cmd_ready_o), 32'd1);
        cmd_valid_i = 1'b1;
        cmd_addr_i  = a;
        cmd_len_i   = l;
        @(posedge clk_i);
        for (int i = 0; i < int'(l); i++) begin
            logic [AW-1:0] ea;
            word_t w;
            ea = a + AW'(i);
            w.data = ram[ea];
            w.last = (i == int'(l) - 1);
            exp_addr_q.push_back(ea);
            exp_q.push_back(w);
        end
        #1;
        cmd_valid_i = 1'b0;
        cmd_addr_i  = '0;
        cmd_len_i   = '0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (!(cmd_ready_o && exp_q.size() == 0) && n < limit) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check("idle_within_bound", 32'(cmd_ready_o && exp_q.size() == 0), 32'd1);
    endtask

    task automatic randomize_ram();
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic          s_rd [1:6];
        logic [AW-1:0] s_ad [1:6];
        logic          s_tv [1:6];
        logic [DW-1:0] s_td [1:6];
        logic          s_tl [1:6];
        logic          s_cr [1:6];
        int            w_addr [4] = '{30, 31, 0, 1};
        int            w_data [4] = '{8'h2E, 8'h2F, 8'h10, 8'h11};
        int            tput_len [4] = '{1, 2, 17, 32};
        int            h0, i0, l0, cyc;

        for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i + 8'h10);

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_rd", 32'(rd_o), 32'd0);
        check("rst_rd_addr", 32'(rd_addr_o), 32'd0);
        check("rst_tvalid", 32'(tvalid_o), 32'd0);
        check("rst_tdata", 32'(tdata_o), 32'd0);
        check("rst_tlast", 32'(tlast_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Basic burst addr=4 len=3, cycle-exact
        tready_mode = 1;
        send_cmd(5'd4, 6'd3);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_i);
            s_rd[k] = rd_o; s_ad[k] = rd_addr_o; s_tv[k] = tvalid_o;
            s_td[k] = tdata_o; s_tl[k] = tlast_o; s_cr[k] = cmd_ready_o;
        end
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("basic_rd_c%0d", k), 32'(s_rd[k]), 32'(k <= 3));
            if (k <= 3) check($sformatf("basic_addr_c%0d", k), 32'(s_ad[k]), 32'(3 + k));
            check($sformatf("basic_tvalid_c%0d", k), 32'(s_tv[k]), 32'(k >= 3 && k <= 5));
            if (k >= 3 && k <= 5) begin
                check($sformatf("basic_tdata_c%0d", k), 32'(s_td[k]), 32'(8'h11 + k));
                check($sformatf("basic_tlast_c%0d", k), 32'(s_tl[k]), 32'(k == 5));
            end
            check($sformatf("basic_cmd_ready_c%0d", k), 32'(s_cr[k]), 32'(k == 6));
        end
        wait_idle(20);

        // Address wrap addr=30 len=4
        send_cmd(5'd30, 6'd4);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_i);
            s_rd[k] = rd_o; s_ad[k] = rd_addr_o; s_td[k] = tdata_o; s_tl[k] = tlast_o;
        end
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("wrap_addr_c%0d", k), 32'(s_ad[k]), 32'(w_addr[k-1]));
            check($sformatf("wrap_tdata_c%0d", k + 2), 32'(s_td[k+2]), 32'(w_data[k-1]));
        end
        check("wrap_tlast_c6", 32'(s_tl[6]), 32'd1);
        wait_idle(20);

        // Backpressure: len=8 with tready low through cycle 10
        tready_mode = 0;
        h0 = hs_count;
        send_cmd(5'd10, 6'd8);
        i0 = issued;
        repeat (10) @(posedge clk_i);
        #1;
        check("bp_reads_while_stalled", 32'(issued - i0), 32'd3);
        check("bp_no_handshake", 32'(hs_count - h0), 32'd0);
        check("bp_tvalid_held", 32'(tvalid_o), 32'd1);
        tready_mode = 1;
        wait_idle(50);
        check("bp_word_count", 32'(hs_count - h0), 32'd8);

        // Full-RAM burst with random tready
        randomize_ram();
        tready_mode = 2;
        h0 = hs_count;
        l0 = last_count;
        send_cmd(AW'($urandom), 6'd32);
        wait_idle(400);
        check("full_word_count", 32'(hs_count - h0), 32'd32);
        check("full_tlast_count", 32'(last_count - l0), 32'd1);
        check("full_last_was_tlast", 32'(last_hs_last), 32'd1);
        check("full_busy_after", 32'(busy_o), 32'd0);

        // Throughput: N words take N+3 cycles to the return of cmd_ready
        tready_mode = 1;
        for (int t = 0; t < 4; t++) begin
            send_cmd(AW'($urandom), LW'(tput_len[t]));
            cyc = 1;
            while (!cmd_ready_o && cyc < 100) begin
                @(posedge clk_i);
                #1;
                cyc++;
            end
            check($sformatf("tput_len%0d", tput_len[t]), 32'(cyc), 32'(tput_len[t] + 3));
            wait_idle(10);
        end

        // len=0 command
        h0 = hs_count;
        send_cmd(5'd7, 6'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            check("len0_busy", 32'(busy_o), 32'd0);
            check("len0_cmd_ready", 32'(cmd_ready_o), 32'd1);
            check("len0_rd", 32'(rd_o), 32'd0);
            check("len0_tvalid", 32'(tvalid_o), 32'd0);
        end
        @(posedge clk_i);
        #1;

        // Random bursts
        for (int b = 0; b < 8; b++) begin
            randomize_ram();
            tready_mode = 2;
            send_cmd(AW'($urandom), LW'($urandom_range(0, 32)));
            wait_idle(500);
        end

        // Reset with two words buffered mid-burst
        tready_mode = 0;
        send_cmd(5'd5, 6'd8);
        repeat (3) @(posedge clk_i);
        #1;
        check("midrst_two_buffered", 32'(tvalid_o), 32'd1);
        rst_i = 1'b1;
        #1;
        exp_q.delete();
        exp_addr_q.delete();
        check("midrst_rd", 32'(rd_o), 32'd0);
        check("midrst_rd_addr", 32'(rd_addr_o), 32'd0);
        check("midrst_tvalid", 32'(tvalid_o), 32'd0);
        check("midrst_tdata", 32'(tdata_o), 32'd0);
        check("midrst_tlast", 32'(tlast_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        tready_mode = 1;
        h0 = hs_count;
        repeat (4) @(posedge clk_i);
        #1;
        check("midrst_no_stray_words", 32'(hs_count - h0), 32'd0);
        send_cmd(5'd0, 6'd1);
        wait_idle(20);
        check("postrst_word_count", 32'(hs_count - h0), 32'd1);
        check("postrst_data", 32'(last_hs_data), 32'(ram[0]));
        check("postrst_tlast", 32'(last_hs_last), 32'd1);

        check("model_drained", 32'(exp_q.size() + exp_addr_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
